// File: rtl/div.sv
// Iterative 32-bit radix-2 restoring divider for the EX stage: one quotient bit per cycle,
// result returned as {remainder, quotient} for the HI/LO write path.
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t              state;
    logic [5:0]          cnt;
    logic [2*DATA_W-1:0] work;       // {partial remainder, dividend/quotient}
    logic [DATA_W-1:0]   divisor_r;
    logic                sign1;
    logic                sign2;
    logic [DATA_W:0]     trial;

    // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned.
    function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] v);
        logic [DATA_W-1:0] m;
        m = v[DATA_W-1] ? -v : v;
        return m;
    endfunction

    function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic c);
        return c ? (~v + 32'd1) : v;
    endfunction

    // Upper 33 bits of the left-shifted working register minus the divisor.
    always_comb begin
        trial = work[2*DATA_W-1:DATA_W-1] - {1'b0, divisor_r};
    end

    // Operand capture while idle, one restoring step per ON cycle.
    always_ff @(posedge clk) begin
        if (state == FREE) begin
            if (signed_div_i) begin
                work      <= {32'd0, mag(opdata1_i)};
                divisor_r <= mag(opdata2_i);
                sign1     <= opdata1_i[DATA_W-1];
                sign2     <= opdata2_i[DATA_W-1];
            end else begin
                work      <= {32'd0, opdata1_i};
                divisor_r <= opdata2_i;
                sign1     <= 1'b0;
                sign2     <= 1'b0;
            end
        end else if (state == ON && !cnt[5]) begin
            if (!trial[DATA_W])
                work <= {trial[DATA_W-1:0], work[DATA_W-2:0], 1'b1};
            else
                work <= {work[2*DATA_W-2:0], 1'b0};
        end
    end

    // Control FSM with registered result/ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FREE;
            cnt      <= 6'd0;
            ready_o  <= 1'b0;
            result_o <= 64'd0;
        end else begin
            case (state)
                FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= 64'd0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == 32'd0) begin
                            state <= BYZERO;
                        end else begin
                            state <= ON;
                            cnt   <= 6'd0;
                        end
                    end
                end
                BYZERO: begin
                    state    <= END;
                    ready_o  <= 1'b1;
                    result_o <= 64'd0;
                end
                ON: begin
                    if (annul_i) begin
                        state <= FREE;
                    end else if (!cnt[5]) begin
                        cnt <= cnt + 6'd1;
                    end else begin
                        // Unsigned operands carry zero sign flags, so they pass through.
                        state    <= END;
                        ready_o  <= 1'b1;
                        result_o <= {neg_if(work[2*DATA_W-1:DATA_W], sign1),
                                     neg_if(work[DATA_W-1:0], sign1 ^ sign2)};
                    end
                end
                END: begin
                    if (!start_i) begin
                        state    <= FREE;
                        ready_o  <= 1'b0;
                        result_o <= 64'd0;
                    end
                end
                default: begin
                    state    <= FREE;
                    ready_o  <= 1'b0;
                    result_o <= 64'd0;
                end
            endcase
        end
    end

endmodule
